// File: rtl/spec_fetch_pair_queue_pkg.sv
// Shared definitions for the speculative-fetch pair queue.
package spec_fetch_pair_queue_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int IW_DEF    = 32;
    localparam int SCW_DEF   = 16;

    // Number of entries retired in one cycle, as driven on issue_count.
    typedef enum logic [1:0] {
        ISSUE_NONE   = 2'd0,
        ISSUE_SINGLE = 2'd1,
        ISSUE_DUAL   = 2'd2
    } issue_e;

endpackage

// File: rtl/spec_fetch_pair_ram.sv
// DEPTH x IW register array: one write port and two asynchronous read ports.
module spec_fetch_pair_ram #(
    parameter int DEPTH = 4,
    parameter int IW    = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [AW-1:0] raddr0,
    input  logic [AW-1:0] raddr1,
    output logic [IW-1:0] rdata0,
    output logic [IW-1:0] rdata1
);

    logic [IW-1:0] mem [DEPTH];

    // Storage has no reset; unused slots are never presented as valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/spec_fetch_pair_queue.sv
// Prefetch queue presenting its two oldest words as a normal/speculative pair.
//
// Handshakes:
//   fetch side: a word transfers on a rising edge where fetch_valid and
//   fetch_ready are both 1. fetch_ready depends only on registered occupancy
//   and flush, never on fetch_valid or on a same-cycle retire.
//   issue side: normal_valid / speculative_valid flag the presented pair;
//   issue_count reports how many of them retire at the coming edge. It is
//   nonzero only when issue_ready is 1, and it reads pair_not_conflict
//   combinationally to decide between one and two.
module spec_fetch_pair_queue
    import spec_fetch_pair_queue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int IW    = IW_DEF,
    parameter int SCW   = SCW_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           fetch_valid,
    input  logic [IW-1:0]  fetch_instr,
    output logic           fetch_ready,
    output logic [IW-1:0]  instruction_normal,
    output logic           normal_valid,
    output logic [IW-1:0]  instruction_speculative,
    output logic           speculative_valid,
    input  logic           pair_not_conflict,
    input  logic           issue_ready,
    output logic [1:0]     issue_count,
    output logic [SCW-1:0] dual_issue_total
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr_next_entry;
    logic [CW-1:0] count;
    logic          push;
    issue_e        issue;
    logic [IW-1:0] head_word;
    logic [IW-1:0] next_word;

    assign rd_ptr_next_entry = rd_ptr + AW'(1);

    spec_fetch_pair_ram #(
        .DEPTH (DEPTH),
        .IW    (IW),
        .AW    (AW)
    ) u_ram (
        .clk    (clk),
        .we     (push),
        .waddr  (wr_ptr),
        .wdata  (fetch_instr),
        .raddr0 (rd_ptr),
        .raddr1 (rd_ptr_next_entry),
        .rdata0 (head_word),
        .rdata1 (next_word)
    );

    assign normal_valid      = (count != '0);
    assign speculative_valid = (count >= CW'(2));

    assign instruction_normal      = normal_valid      ? head_word : '0;
    assign instruction_speculative = speculative_valid ? next_word : '0;

    // A full queue refuses even when a retire is under way this cycle.
    assign fetch_ready = (count != CW'(DEPTH)) && !flush;
    assign push        = fetch_valid && fetch_ready;

    // Retire decision: pair goes together only when the judge sees no conflict.
    always_comb begin
        issue = ISSUE_NONE;
        if (issue_ready && normal_valid && !flush) begin
            if (speculative_valid && pair_not_conflict) begin
                issue = ISSUE_DUAL;
            end else begin
                issue = ISSUE_SINGLE;
            end
        end
    end

    assign issue_count = issue;

    // Pointer and occupancy update; flush discards everything this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= AW'(CW'(rd_ptr) + CW'(issue_count));
            count  <= count + CW'(push) - CW'(issue_count);
        end
    end

    // Saturating dual-issue counter; survives flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dual_issue_total <= '0;
        end else if ((issue == ISSUE_DUAL) && (dual_issue_total != '1)) begin
            dual_issue_total <= dual_issue_total + SCW'(1);
        end
    end

endmodule

// File: tb/tb_spec_fetch_pair_queue.sv
// Directed bench for spec_fetch_pair_queue: vector table plus corner sequences.
module tb_spec_fetch_pair_queue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_ready;
    logic [31:0] instruction_normal;
    logic        normal_valid;
    logic [31:0] instruction_speculative;
    logic        speculative_valid;
    logic        pair_not_conflict;
    logic        issue_ready;
    logic [1:0]  issue_count;
    logic [15:0] dual_issue_total;

    // Narrow-counter instance sharing the same stimulus, to reach saturation quickly.
    logic        s_fetch_ready;
    logic [31:0] s_instruction_normal;
    logic        s_normal_valid;
    logic [31:0] s_instruction_speculative;
    logic        s_speculative_valid;
    logic [1:0]  s_issue_count;
    logic [1:0]  s_dual_issue_total;

    int n_vec;
    int n_fail;

    spec_fetch_pair_queue dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .flush                   (flush),
        .fetch_valid             (fetch_valid),
        .fetch_instr             (fetch_instr),
        .fetch_ready             (fetch_ready),
        .instruction_normal      (instruction_normal),
        .normal_valid            (normal_valid),
        .instruction_speculative (instruction_speculative),
        .speculative_valid       (speculative_valid),
        .pair_not_conflict       (pair_not_conflict),
        .issue_ready             (issue_ready),
        .issue_count             (issue_count),
        .dual_issue_total        (dual_issue_total)
    );

    spec_fetch_pair_queue #(.SCW(2)) dut_sat (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .flush                   (flush),
        .fetch_valid             (fetch_valid),
        .fetch_instr             (fetch_instr),
        .fetch_ready             (s_fetch_ready),
        .instruction_normal      (s_instruction_normal),
        .normal_valid            (s_normal_valid),
        .instruction_speculative (s_instruction_speculative),
        .speculative_valid       (s_speculative_valid),
        .pair_not_conflict       (pair_not_conflict),
        .issue_ready             (issue_ready),
        .issue_count             (s_issue_count),
        .dual_issue_total        (s_dual_issue_total)
    );

    // Clock and reset defaults.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        fv;
        logic [31:0] fi;
        logic        pnc;
        logic        ir;
        logic        fl;
        logic        nv;
        logic        sv;
        logic [31:0] n;
        logic [31:0] s;
        logic        fr;
        logic [1:0]  ic;
        logic [15:0] tot;
    } vec_t;

    vec_t vq[$];
    logic [31:0] exp_q[$];

    task automatic add(input logic fv, input logic [31:0] fi, input logic pnc,
                       input logic ir, input logic fl, input logic nv, input logic sv,
                       input logic [31:0] n, input logic [31:0] s, input logic fr,
                       input logic [1:0] ic, input logic [15:0] tot);
        vec_t v;
        v.fv = fv; v.fi = fi; v.pnc = pnc; v.ir = ir; v.fl = fl;
        v.nv = nv; v.sv = sv; v.n = n; v.s = s; v.fr = fr; v.ic = ic; v.tot = tot;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fv, input logic [31:0] fi, input logic pnc,
                         input logic ir, input logic fl);
        fetch_valid = fv; fetch_instr = fi; pair_not_conflict = pnc;
        issue_ready = ir; flush = fl;
    endtask

    // Inputs change at posedge+1; outputs are checked at posedge+5.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".normal_valid"}, 32'(normal_valid), 32'd0);
        chk({tag, ".speculative_valid"}, 32'(speculative_valid), 32'd0);
        chk({tag, ".fetch_ready"}, 32'(fetch_ready), 32'd1);
        chk({tag, ".issue_count"}, 32'(issue_count), 32'd0);
    endtask

    // Occupancy must stay within 0..DEPTH.
    always @(negedge clk) begin
        if (rst_n && (dut.count > 3'd4)) begin
            n_fail++;
            $display("FAIL count_invariant: got %0d, limit 4", dut.count);
        end
    end

    initial begin
        n_vec  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        //  fv  fi            pnc ir  fl | nv  sv  n             s             fr  ic  tot
        add(1, 32'h11111111, 0, 0, 0,   0, 0, 32'h0,        32'h0,        1, 0, 0); // 1
        add(0, 32'h0,        1, 1, 0,   1, 0, 32'h11111111, 32'h0,        1, 1, 0); // 2 single retire
        add(0, 32'h0,        0, 0, 0,   0, 0, 32'h0,        32'h0,        1, 0, 0); // 3 empty again
        add(1, 32'hA0,       0, 0, 0,   0, 0, 32'h0,        32'h0,        1, 0, 0); // 4
        add(1, 32'hB0,       0, 0, 0,   1, 0, 32'hA0,       32'h0,        1, 0, 0); // 5
        add(1, 32'hC0,       0, 0, 0,   1, 1, 32'hA0,       32'hB0,       1, 0, 0); // 6
        add(0, 32'h0,        1, 1, 0,   1, 1, 32'hA0,       32'hB0,       1, 2, 0); // 7 dual
        add(0, 32'h0,        1, 1, 0,   1, 0, 32'hC0,       32'h0,        1, 1, 1); // 8
        add(1, 32'hA0,       0, 0, 0,   0, 0, 32'h0,        32'h0,        1, 0, 1); // 9
        add(1, 32'hB0,       0, 0, 0,   1, 0, 32'hA0,       32'h0,        1, 0, 1); // 10
        add(1, 32'hC0,       0, 0, 0,   1, 1, 32'hA0,       32'hB0,       1, 0, 1); // 11
        add(0, 32'h0,        0, 1, 0,   1, 1, 32'hA0,       32'hB0,       1, 1, 1); // 12 conflict
        add(0, 32'h0,        0, 0, 0,   1, 1, 32'hB0,       32'hC0,       1, 0, 1); // 13
        add(0, 32'h0,        1, 1, 0,   1, 1, 32'hB0,       32'hC0,       1, 2, 1); // 14
        add(1, 32'h1,        0, 0, 0,   0, 0, 32'h0,        32'h0,        1, 0, 2); // 15
        add(1, 32'h2,        0, 0, 0,   1, 0, 32'h1,        32'h0,        1, 0, 2); // 16
        add(1, 32'h3,        0, 0, 0,   1, 1, 32'h1,        32'h2,        1, 0, 2); // 17
        add(1, 32'h4,        0, 0, 0,   1, 1, 32'h1,        32'h2,        1, 0, 2); // 18 becomes full
        add(1, 32'h5,        0, 0, 0,   1, 1, 32'h1,        32'h2,        0, 0, 2); // 19 5th held
        add(1, 32'h5,        0, 1, 0,   1, 1, 32'h1,        32'h2,        0, 1, 2); // 20 pop, no push
        add(1, 32'h5,        0, 0, 0,   1, 1, 32'h2,        32'h3,        1, 0, 2); // 21 slot free
        add(0, 32'h0,        0, 1, 0,   1, 1, 32'h2,        32'h3,        0, 1, 2); // 22
        add(1, 32'h6,        1, 1, 1,   1, 1, 32'h3,        32'h4,        0, 0, 2); // 23 flush
        add(0, 32'h0,        0, 0, 0,   0, 0, 32'h0,        32'h0,        1, 0, 2); // 24 empty

        // Reset and three idle cycles.
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #4;
            chk_idle($sformatf("reset_idle%0d", i));
            chk("reset_idle.total", 32'(dual_issue_total), 32'd0);
            tick();
        end

        // Table-driven section.
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].fv, vq[i].fi, vq[i].pnc, vq[i].ir, vq[i].fl);
            #4;
            chk($sformatf("v%0d.normal_valid", i + 1), 32'(normal_valid), 32'(vq[i].nv));
            chk($sformatf("v%0d.speculative_valid", i + 1), 32'(speculative_valid), 32'(vq[i].sv));
            chk($sformatf("v%0d.instruction_normal", i + 1), instruction_normal, vq[i].n);
            chk($sformatf("v%0d.instruction_speculative", i + 1), instruction_speculative, vq[i].s);
            chk($sformatf("v%0d.fetch_ready", i + 1), 32'(fetch_ready), 32'(vq[i].fr));
            chk($sformatf("v%0d.issue_count", i + 1), 32'(issue_count), 32'(vq[i].ic));
            chk($sformatf("v%0d.dual_issue_total", i + 1), 32'(dual_issue_total), 32'(vq[i].tot));
            tick();
        end

        // Steady push/pop across the pointer wrap with three entries resident.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0);
            exp_q.push_back(32'h100 + 32'(i));
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h200 + 32'(i), 1'b0, 1'b1, 1'b0);
            exp_q.push_back(32'h200 + 32'(i));
            #4;
            chk($sformatf("wrap%0d.normal", i), instruction_normal, exp_q[0]);
            chk($sformatf("wrap%0d.spec", i), instruction_speculative, exp_q[1]);
            chk($sformatf("wrap%0d.issue_count", i), 32'(issue_count), 32'd1);
            chk($sformatf("wrap%0d.fetch_ready", i), 32'(fetch_ready), 32'd1);
            chk($sformatf("wrap%0d.count", i), 32'(dut.count), 32'd3);
            tick();
            void'(exp_q.pop_front());
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #4;
        chk("wrap_end.normal", instruction_normal, exp_q[0]);
        chk("wrap_end.spec", instruction_speculative, exp_q[1]);
        tick();

        // Flush while idle, then dual issues to saturate the 2-bit counter.
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0, 1'b0);
            tick();
            drive(1'b1, 32'h310 + 32'(i), 1'b0, 1'b0, 1'b0);
            tick();
            drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
            #4;
            chk($sformatf("sat%0d.issue_count", i), 32'(issue_count), 32'd2);
            chk($sformatf("sat%0d.normal", i), instruction_normal, 32'h300 + 32'(i));
            tick();
            drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            #4;
            chk($sformatf("sat%0d.total", i), 32'(dual_issue_total), 32'd3 + 32'(i));
            chk($sformatf("sat%0d.narrow_total", i), 32'(s_dual_issue_total), 32'd3);
            chk($sformatf("sat%0d.empty", i), 32'(normal_valid), 32'd0);
            tick();
        end

        // Asynchronous reset in the middle of operation.
        drive(1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h401, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        #2;
        chk("pre_reset.normal_valid", 32'(normal_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_idle("mid_reset");
        chk("mid_reset.total", 32'(dual_issue_total), 32'd0);
        chk("mid_reset.narrow_total", 32'(s_dual_issue_total), 32'd0);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #4;
        chk_idle("post_reset");
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
